// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// instruction_loader : framed UART byte stream -> instruction bank writes
// Revision 1.0
// ============================================================================
module instruction_loader #(
   parameter int INST_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk_100mhz,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [INST_WIDTH-1:0] wr_data,
   output logic [ADDR_WIDTH:0]   prog_len,
   output logic                  prog_valid,
   output logic                  loading,
   output logic                  load_err
);

   localparam int c_BYTES = INST_WIDTH / 8;
   localparam int c_BW    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
   localparam int c_LW    = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;
   localparam int c_TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [c_LW-1:0] c_MAX_LEN   = c_LW'(1) << ADDR_WIDTH;
   localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(c_BYTES - 1);
   localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      c_SYNC      = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t                r_state;
   logic [c_BW-1:0]       r_byte;
   logic [ADDR_WIDTH:0]   r_widx;
   logic [ADDR_WIDTH:0]   r_len;
   logic [7:0]            r_chk;
   logic [c_TW-1:0]       r_tmo;
   logic [INST_WIDTH-1:0] r_word;

   logic                  r_rx_ready;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [INST_WIDTH-1:0] r_wr_data;
   logic [ADDR_WIDTH:0]   r_prog_len;
   logic                  r_prog_valid;
   logic                  r_loading;
   logic                  r_load_err;

   logic                  w_accept;
   logic [c_LW-1:0]       w_len_full;
   logic [INST_WIDTH-1:0] w_word_next;
   logic                  w_last_word;
   logic                  w_tmo_hit;
   logic                  w_in_frame;

   assign w_accept    = rx_valid & r_rx_ready;
   assign w_last_word = (r_widx == r_len - 1'b1);
   assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
   assign w_in_frame  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);

   // A LEN byte of zero stands for a full bank only when the byte can't express it.
   always_comb begin
      w_len_full = c_LW'(rx_data);
      if (rx_data == 8'd0 && ADDR_WIDTH == 8)
         w_len_full = c_MAX_LEN;
   end

   always_comb begin
      w_word_next = r_word;
      w_word_next[r_byte*8 +: 8] = rx_data;
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_byte       <= '0;
         r_widx       <= '0;
         r_len        <= '0;
         r_chk        <= '0;
         r_tmo        <= '0;
         r_word       <= '0;
         r_rx_ready   <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_prog_len   <= '0;
         r_prog_valid <= 1'b0;
         r_loading    <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_wr_en    <= 1'b0;
         r_load_err <= 1'b0;
         r_rx_ready <= 1'b1;

         case (r_state)
            // ERR still accepts bytes, so it must also recognise a new SYNC
            S_IDLE, S_ERR: begin
               r_state <= S_IDLE;
               if (w_accept && rx_data == c_SYNC) begin
                  r_state      <= S_LEN;
                  r_loading    <= 1'b1;
                  r_prog_valid <= 1'b0;
               end
            end
            S_LEN: begin
               if (w_accept) begin
                  r_len  <= w_len_full[ADDR_WIDTH:0];
                  r_chk  <= rx_data;
                  r_byte <= '0;
                  r_widx <= '0;
                  r_word <= '0;
                  if (w_len_full > c_MAX_LEN) begin
                     r_state    <= S_ERR;
                     r_load_err <= 1'b1;
                     r_loading  <= 1'b0;
                  end else if (w_len_full == '0) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_word <= w_word_next;
                  r_chk  <= r_chk ^ rx_data;
                  if (r_byte == c_LAST_BYTE) begin
                     r_byte    <= '0;
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_widx[ADDR_WIDTH-1:0];
                     r_wr_data <= w_word_next;
                     r_widx    <= r_widx + 1'b1;
                     if (w_last_word)
                        r_state <= S_CHECK;
                  end else begin
                     r_byte <= r_byte + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               if (w_accept) begin
                  r_loading <= 1'b0;
                  if (rx_data == r_chk) begin
                     r_state      <= S_DONE;
                     r_prog_len   <= r_len;
                     r_prog_valid <= 1'b1;
                     r_rx_ready   <= 1'b0;
                  end else begin
                     r_state    <= S_ERR;
                     r_load_err <= 1'b1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // Inactivity watchdog; only counts while a frame is open and no byte arrives
         if (w_in_frame) begin
            if (w_accept) begin
               r_tmo <= '0;
            end else if (w_tmo_hit) begin
               r_tmo      <= '0;
               r_state    <= S_ERR;
               r_load_err <= 1'b1;
               r_loading  <= 1'b0;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end else begin
            r_tmo <= '0;
         end
      end
   end

   assign rx_ready   = r_rx_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign prog_len   = r_prog_len;
   assign prog_valid = r_prog_valid;
   assign loading    = r_loading;
   assign load_err   = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// tb_instruction_loader : directed frames with hand-computed expectations
// Revision 1.0
// ============================================================================
module tb_instruction_loader;

   localparam int INST_WIDTH     = 64;
   localparam int ADDR_WIDTH     = 8;
   localparam int TIMEOUT_CYCLES = 100;

   logic                  clk_100mhz = 1'b0;
   logic                  rst_n;
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [INST_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH:0]   prog_len;
   logic                  prog_valid;
   logic                  loading;
   logic                  load_err;

   int n_total = 0;
   int n_bad   = 0;

   logic [ADDR_WIDTH-1:0] wq_addr[$];
   logic [INST_WIDTH-1:0] wq_data[$];

   instruction_loader #(
      .INST_WIDTH    (INST_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_dut (
      .clk_100mhz(clk_100mhz),
      .rst_n     (rst_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .prog_len  (prog_len),
      .prog_valid(prog_valid),
      .loading   (loading),
      .load_err  (load_err)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   always @(negedge clk_100mhz) begin
      if (rst_n && wr_en) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds the byte from a falling edge until the rising edge that accepts it
   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      @(negedge clk_100mhz);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && w < 20) begin
         @(negedge clk_100mhz);
         w++;
      end
      if (!rx_ready) check_val("rdy_wait", {63'd0, rx_ready}, 64'd1);
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic clear_writes();
      wq_addr.delete();
      wq_data.delete();
   endtask

   // LEN=1 frame carrying bytes 0x10..0x17; checksum 0x01
   task automatic send_frame_one();
      send_byte(8'hA5);
      send_byte(8'h01);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
      send_byte(8'h01);
      rx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      bit seen;

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk_100mhz);
      check_val("rst_rx_ready",   {63'd0, rx_ready},   64'd0);
      check_val("rst_wr_en",      {63'd0, wr_en},      64'd0);
      check_val("rst_wr_addr",    64'(wr_addr),        64'd0);
      check_val("rst_wr_data",    wr_data,             64'd0);
      check_val("rst_prog_len",   64'(prog_len),       64'd0);
      check_val("rst_prog_valid", {63'd0, prog_valid}, 64'd0);
      check_val("rst_loading",    {63'd0, loading},    64'd0);
      check_val("rst_load_err",   {63'd0, load_err},   64'd0);
      rst_n = 1'b1;

      // Good two-word program
      clear_writes();
      send_byte(8'hA5);
      send_byte(8'h02);
      check_val("t1_loading", {63'd0, loading}, 64'd1);
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_byte(8'h02);
      rx_valid = 1'b0;
      check_val("t1_prog_valid", {63'd0, prog_valid}, 64'd1);
      check_val("t1_prog_len",   64'(prog_len),       64'd2);
      check_val("t1_loading_off", {63'd0, loading},   64'd0);
      check_val("t1_rdy_done",   {63'd0, rx_ready},   64'd0);
      check_val("t1_nwr",  64'(wq_addr.size()), 64'd2);
      check_val("t1_a0",   64'(wq_addr[0]), 64'd0);
      check_val("t1_d0",   wq_data[0], 64'h0706050403020100);
      check_val("t1_a1",   64'(wq_addr[1]), 64'd1);
      check_val("t1_d1",   wq_data[1], 64'h0F0E0D0C0B0A0908);

      // Same frame, wrong checksum
      clear_writes();
      send_byte(8'hA5);
      send_byte(8'h02);
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_byte(8'h03);
      rx_valid = 1'b0;
      check_val("t2_load_err",   {63'd0, load_err},   64'd1);
      check_val("t2_prog_valid", {63'd0, prog_valid}, 64'd0);
      check_val("t2_prog_len",   64'(prog_len),       64'd2);
      check_val("t2_loading",    {63'd0, loading},    64'd0);
      check_val("t2_nwr",        64'(wq_addr.size()), 64'd2);
      check_val("t2_d1",         wq_data[1], 64'h0F0E0D0C0B0A0908);
      @(posedge clk_100mhz);
      #1;
      check_val("t2_err_pulse",  {63'd0, load_err},   64'd0);

      // Leading garbage is discarded
      clear_writes();
      send_byte(8'h11);
      send_byte(8'h22);
      send_frame_one();
      check_val("t3_prog_valid", {63'd0, prog_valid}, 64'd1);
      check_val("t3_prog_len",   64'(prog_len),       64'd1);
      check_val("t3_nwr",        64'(wq_addr.size()), 64'd1);
      check_val("t3_a0",         64'(wq_addr[0]), 64'd0);
      check_val("t3_d0",         wq_data[0], 64'h1716151413121110);

      // 0xA5 inside payload is plain data
      clear_writes();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'hA5);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'hA0);
      rx_valid = 1'b0;
      check_val("t5_prog_valid", {63'd0, prog_valid}, 64'd1);
      check_val("t5_nwr",        64'(wq_addr.size()), 64'd1);
      check_val("t5_d0",         wq_data[0], 64'h04030201A500A5A5);

      // Silence mid-frame trips the timeout
      clear_writes();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      rx_valid = 1'b0;
      c    = 0;
      seen = 1'b0;
      for (int k = 1; k <= 200 && !seen; k++) begin
         @(posedge clk_100mhz);
         #1;
         if (load_err) begin
            seen = 1'b1;
            c    = k;
         end
      end
      check_val("t4_tmo_cycles", 64'(c), 64'd100);
      check_val("t4_loading",    {63'd0, loading},    64'd0);
      check_val("t4_prog_valid", {63'd0, prog_valid}, 64'd0);
      check_val("t4_prog_len",   64'(prog_len),       64'd1);
      check_val("t4_nwr",        64'(wq_addr.size()), 64'd0);
      @(posedge clk_100mhz);
      #1;
      check_val("t4_err_pulse",  {63'd0, load_err},   64'd0);
      check_val("t4_rdy_idle",   {63'd0, rx_ready},   64'd1);

      // Asynchronous reset mid-DATA, then a clean reload
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      @(negedge clk_100mhz);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_loading",    {63'd0, loading},    64'd0);
      check_val("t6_rx_ready",   {63'd0, rx_ready},   64'd0);
      check_val("t6_prog_len",   64'(prog_len),       64'd0);
      check_val("t6_prog_valid", {63'd0, prog_valid}, 64'd0);
      @(negedge clk_100mhz);
      rst_n = 1'b1;
      clear_writes();
      send_frame_one();
      check_val("t6_reload_valid", {63'd0, prog_valid}, 64'd1);
      check_val("t6_reload_len",   64'(prog_len),       64'd1);
      check_val("t6_reload_nwr",   64'(wq_addr.size()), 64'd1);
      check_val("t6_reload_d0",    wq_data[0], 64'h1716151413121110);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
